// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, byte-array views and GF(2^8) helpers
// for the iterative AES-style decrypt datapath.
package aes_pkg;
  localparam int NUM_ROUNDS_DEF = 10;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  typedef logic [3:0][3:0][7:0] bytes_t;
  function automatic bytes_t unpack(input logic [127:0] d);
    return d;
  endfunction
  function automatic logic [127:0] pack(input bytes_t b);
    return b;
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t, r;
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/addroundkey.sv
// addroundkey: XOR of the block state with a round key.
module addroundkey (
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  output logic [127:0] o_state
);
  assign o_state = i_state ^ i_key;
endmodule

// File: rtl/reverseround.sv
// reverseround: one inverse round -- add round key, inverse shift rows,
// inverse substitute bytes.
module reverseround
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  output logic [127:0] o_state
);
  bytes_t w_x, w_y;
  assign w_x = unpack(i_state ^ i_key);
  // row r was rotated left by r on encrypt, so pull each byte back from column c-r
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_y[r][c] = inv_sbox(w_x[r][(c + 4 - r) % 4]);
    end
  end
  assign o_state = pack(w_y);
endmodule

// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: iterative block decryptor that reuses a single
// reverseround datapath for every round, fetching keys from an external store.
module decrypt_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         key_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy
);
  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [KEY_IDX_W-1:0] ONE = KEY_IDX_W'(1);
  state_t               r_state;
  logic [KEY_IDX_W-1:0] r_cnt;
  logic [127:0]         r_data, w_round, w_final;
  reverseround u_round (.i_state(r_data), .i_key(key_data), .o_state(w_round));
  addroundkey  u_ark   (.i_state(r_data), .i_key(key_data), .o_state(w_final));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_state <= ROUND;
          r_cnt   <= LAST_IDX;
          r_data  <= in_data;
        end
        ROUND: begin
          r_data <= w_round;
          r_cnt  <= r_cnt - ONE;
          if (r_cnt == ONE) r_state <= FINAL;
        end
        FINAL: begin
          r_data  <= w_final;
          r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // key index parks on the first round key outside ROUND/FINAL so the store can prefetch
  assign key_idx   = r_state == ROUND ? r_cnt : r_state == FINAL ? '0 : LAST_IDX;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign out_data  = r_data;
endmodule

// File: tb/tb_decrypt_sequencer.sv
// tb_decrypt_sequencer: randomized self-checking bench against a table-driven
// decrypt model; covers latency, key trace, backpressure, back-to-back, reset.
module tb_decrypt_sequencer;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [127:0] in_data = '0, key_data, out_data;
  logic [3:0] key_idx;
  logic in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1, busy1;
  logic [127:0] in_data1 = '0, key_data1, out_data1;
  logic [0:0] key_idx1;
  logic [7:0] isb [256];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  assign key_data  = {16{8'(key_idx)}};
  assign key_data1 = {16{8'(key_idx1)}};

  decrypt_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_data(key_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );
  decrypt_sequencer #(.NUM_ROUNDS(1), .KEY_IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .key_idx(key_idx1), .key_data(key_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // plaintext = XOR key0 after rounds k=nr..1 of: XOR key k, undo row rotation, inverse S-box
  function automatic logic [127:0] model(input logic [127:0] ct, input int nr);
    logic [127:0] s, t;
    s = ct;
    t = '0;
    for (int k = nr; k >= 1; k--) begin
      s = s ^ {16{8'(k)}};
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[8*(4*r+c) +: 8] = isb[s[8*(4*r+(c+4-r)%4) +: 8]];
      s = t;
    end
    return s ^ {16{8'h00}};
  endfunction

  task automatic do_block(input logic [127:0] d, input int hold);
    int w;
    w = 0;
    out_ready = 0;
    in_valid = 1;
    in_data = d;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    check("accept_wait", 128'(w < 40), 128'(1));
    @(negedge clk);
    in_valid = 1'($urandom_range(1));
    in_data = rnd128();
    w = 0;
    while (!out_valid && w < 40) begin
      check("busy_ready", in_ready, 0);
      @(negedge clk);
      w++;
    end
    check("latency", w, 11);
    check("out_data", out_data, model(d, 10));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, model(d, 10));
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    check("post_idle", out_valid, 0);
    out_ready = 0;
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [127:0] blk [2];
    logic [7:0] inv, sb;
    int w, n_acc, n_out;
    int acc_t [2];
    logic seen;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (fmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      isb[sb] = 8'(x);
    end
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_key_idx", key_idx, 10);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    d = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1;
    in_valid = 1;
    in_data = d;
    check("accept_key_idx", key_idx, 10);
    @(negedge clk);
    in_valid = 0;
    for (int k = 0; k < 12; k++) begin
      check("trace_key_idx", key_idx, k < 10 ? 10 - k : (k == 10 ? 0 : 10));
      check("trace_valid", out_valid, k == 11);
      check("trace_busy", busy, 1);
      if (k < 11) @(negedge clk);
    end
    check("vector_data", out_data, model(d, 10));
    @(negedge clk);
    out_ready = 0;
    check("vector_idle", busy, 0);
    do_block(rnd128(), 5);
    for (int i = 0; i < 6; i++) do_block(rnd128(), $urandom_range(3));
    blk[0] = rnd128();
    blk[1] = rnd128();
    acc_t[0] = 0;
    acc_t[1] = 0;
    n_acc = 0;
    n_out = 0;
    out_ready = 1;
    in_valid = 1;
    in_data = blk[0];
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (in_ready && in_valid && n_acc < 2) begin acc_t[n_acc] = cyc; n_acc++; end
      if (out_valid && n_out < 2) begin
        check("b2b_data", out_data, model(blk[n_out], 10));
        n_out++;
      end
      @(negedge clk);
      in_valid = n_acc < 2;
      in_data = n_acc < 2 ? blk[n_acc] : rnd128();
    end
    check("b2b_gap", acc_t[1] - acc_t[0], 13);
    check("b2b_outputs", n_out, 2);
    out_ready = 0;
    in_valid = 1;
    in_data = rnd128();
    @(negedge clk);
    in_valid = 0;
    w = 0;
    while (key_idx != 5 && w < 20) begin @(negedge clk); w++; end
    check("mid_reach_cnt5", key_idx, 5);
    rst = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_key_idx", key_idx, 10);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); seen |= out_valid; end
    check("mid_rst_no_output", seen, 0);
    do_block(rnd128(), 1);
    d = rnd128();
    check("nr1_in_ready", in_ready1, 1);
    check("nr1_key_idx_idle", key_idx1, 1);
    in_valid1 = 1;
    in_data1 = d;
    @(negedge clk);
    in_valid1 = 0;
    w = 0;
    while (!out_valid1 && w < 10) begin @(negedge clk); w++; end
    check("nr1_latency", w, 2);
    check("nr1_data", out_data1, model(d, 1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
